// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - shared types and AXI constants for the write transfer engine
package axi_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI size encoding: log2 of bytes per beat
  function automatic logic [2:0] calc_awsize(input int data_w);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_w / 8)) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_wr_beat_ctr.sv
// rtl/axi_wr_beat_ctr.sv - 8-bit W beat counter with last-beat compare
module axi_wr_beat_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic [7:0] len,
  output logic [7:0] count,
  output logic       last
);

  // count accepted beats of the current burst; cleared at burst start
  always_ff @(posedge clk) begin
    if (reset || clear) count <= 8'd0;
    else if (inc)       count <= count + 8'd1;
  end

  assign last = (count == len);

endmodule

// File: rtl/axi_wr_xfer_engine.sv
// rtl/axi_wr_xfer_engine.sv - single-burst AXI4 write engine serving three submasters
module axi_wr_xfer_engine
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                grant_0,
  input  logic                grant_1,
  input  logic                grant_2,
  output logic                xfer_done0,
  output logic                xfer_done1,
  output logic                xfer_done2,
  input  logic [ADDR_W-1:0]   sm_addr_0,
  input  logic [ADDR_W-1:0]   sm_addr_1,
  input  logic [ADDR_W-1:0]   sm_addr_2,
  input  logic [7:0]          sm_len_0,
  input  logic [7:0]          sm_len_1,
  input  logic [7:0]          sm_len_2,
  input  logic [DATA_W-1:0]   sm_wdata_0,
  input  logic [DATA_W-1:0]   sm_wdata_1,
  input  logic [DATA_W-1:0]   sm_wdata_2,
  input  logic                sm_wvalid_0,
  input  logic                sm_wvalid_1,
  input  logic                sm_wvalid_2,
  output logic                sm_wready_0,
  output logic                sm_wready_1,
  output logic                sm_wready_2,
  output logic                resp_err_0,
  output logic                resp_err_1,
  output logic                resp_err_2,
  output logic                grant_err,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t              state_q, state_d;
  logic [1:0]          idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic                err_q;
  logic                grant_err_q;
  logic [2:0]          grants;
  logic                any_grant;
  logic                multi_grant;
  logic [1:0]          win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [7:0]          win_len;
  logic [2:0]          idx_oh;
  logic                sel_wvalid;
  logic [DATA_W-1:0]   sel_wdata;
  logic                w_hs;
  logic                start;
  logic [7:0]          beat_count;
  logic                beat_last;
  logic [2:0]          sm_wready_v, xfer_done_v, resp_err_v;

  assign grants      = {grant_2, grant_1, grant_0};
  assign any_grant   = |grants;
  assign multi_grant = (grants[0] & grants[1]) | (grants[0] & grants[2]) | (grants[1] & grants[2]);
  assign start       = (state_q == ST_IDLE) && any_grant;
  assign idx_oh      = 3'b001 << idx_q;
  assign w_hs        = (state_q == ST_W) && sel_wvalid && wready;

  // pick the lowest-numbered granted submaster and its request fields
  always_comb begin
    win_idx  = 2'd2;
    win_addr = sm_addr_2;
    win_len  = sm_len_2;
    if (grants[0]) begin
      win_idx  = 2'd0;
      win_addr = sm_addr_0;
      win_len  = sm_len_0;
    end else if (grants[1]) begin
      win_idx  = 2'd1;
      win_addr = sm_addr_1;
      win_len  = sm_len_1;
    end
  end

  // route the served submaster's W stream
  always_comb begin
    sel_wvalid = 1'b0;
    sel_wdata  = sm_wdata_0;
    case (idx_q)
      2'd0: begin sel_wvalid = sm_wvalid_0; sel_wdata = sm_wdata_0; end
      2'd1: begin sel_wvalid = sm_wvalid_1; sel_wdata = sm_wdata_1; end
      2'd2: begin sel_wvalid = sm_wvalid_2; sel_wdata = sm_wdata_2; end
      default: begin sel_wvalid = 1'b0; sel_wdata = sm_wdata_0; end
    endcase
  end

  // state, request latches, response error capture and grant error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      err_q       <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_err_q <= (state_q == ST_IDLE) ? multi_grant : any_grant;
      if (start) begin
        idx_q  <= win_idx;
        addr_q <= win_addr;
        len_q  <= win_len;
      end
      if ((state_q == ST_B) && bvalid)
        err_q <= (bresp == AXI_RESP_SLVERR) || (bresp == AXI_RESP_DECERR);
    end
  end

  axi_wr_beat_ctr u_beat_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .inc   (w_hs),
    .len   (len_q),
    .count (beat_count),
    .last  (beat_last)
  );

  // next state and channel handshake outputs
  always_comb begin
    state_d     = state_q;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    sm_wready_v = 3'b000;
    xfer_done_v = 3'b000;
    resp_err_v  = 3'b000;
    case (state_q)
      ST_IDLE: if (any_grant) state_d = ST_AW;
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = ST_W;
      end
      ST_W: begin
        wvalid      = sel_wvalid;
        wlast       = beat_last;
        sm_wready_v = idx_oh & {3{wready}};
        if (w_hs && beat_last) state_d = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) state_d = ST_DONE;
      end
      ST_DONE: begin
        xfer_done_v = idx_oh;
        resp_err_v  = idx_oh & {3{err_q}};
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign awaddr      = addr_q;
  assign awlen       = len_q;
  assign awsize      = calc_awsize(DATA_W);
  assign awburst     = AXI_BURST_INCR;
  assign wdata       = sel_wdata;
  assign wstrb       = '1;
  assign grant_err   = grant_err_q;
  assign sm_wready_0 = sm_wready_v[0];
  assign sm_wready_1 = sm_wready_v[1];
  assign sm_wready_2 = sm_wready_v[2];
  assign xfer_done0  = xfer_done_v[0];
  assign xfer_done1  = xfer_done_v[1];
  assign xfer_done2  = xfer_done_v[2];
  assign resp_err_0  = resp_err_v[0];
  assign resp_err_1  = resp_err_v[1];
  assign resp_err_2  = resp_err_v[2];

endmodule

// File: doc/axi_wr_xfer_engine.md
# axi_wr_xfer_engine

Write-channel execution engine sitting directly downstream of the three-way submaster write arbiter. On a one-cycle grant for submaster k it latches that submaster's address/length, runs one AXI4 INCR write burst (AW, then W beats streamed from submaster k, then B), and returns a one-cycle xfer_done to the arbiter. It is the only block driving the AXI write address/data/response channels toward the interconnect.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (power of two, 8..1024)
- clk  input  1  rising-edge clock; one clock for the whole block
- reset  input  1  synchronous, active-high reset
- grant_0 / grant_1 / grant_2  input  1  one-cycle start pulse from the arbiter
- xfer_done0 / xfer_done1 / xfer_done2  output  1  one-cycle completion pulse to the arbiter
- sm_addr_k (k=0..2)  input  ADDR_W  burst start address, sampled on grant_k
- sm_len_k (k=0..2)  input  8  beats minus one (AXI awlen), sampled on grant_k
- sm_wdata_k (k=0..2)  input  DATA_W  write data beat
- sm_wvalid_k (k=0..2)  input  1  beat valid
- sm_wready_k (k=0..2)  output  1  beat accepted
- resp_err_k (k=0..2)  output  1  one-cycle pulse coincident with xfer_done when bresp != OKAY
- grant_err  output  1  one-cycle pulse: grant received while not IDLE
- awaddr  output  ADDR_W; awlen  output  8; awsize  output  3; awburst  output  2
- awvalid  output  1; awready  input  1
- wdata  output  DATA_W; wstrb  output  DATA_W/8; wlast  output  1; wvalid  output  1; wready  input  1
- bresp  input  2; bvalid  input  1; bready  output  1

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE: on any grant_k go AW; latch idx=k, addr, len; clear beat counter. Simultaneous grants: lowest k wins, grant_err pulses.
- AW: awvalid=1, awaddr/awlen from latches, stable until awready. awready -> W.
- W: wvalid = sm_wvalid_idx, wdata = sm_wdata_idx, sm_wready_idx = wready (combinational pass-through); other sm_wready = 0. Beat counter increments per wvalid&wready; wlast = (count == len). Last handshake -> B.
- B: bready=1. bvalid -> DONE; capture bresp[1] as error.
- DONE: xfer_done_idx=1, resp_err_idx=error, -> IDLE.
- Constants: awsize = log2(DATA_W/8), awburst = 2'b01 (INCR), wstrb all ones.
- Grant outside IDLE: ignored (no latch change), grant_err pulses next cycle.
- len = 0: single beat, wlast asserted on first beat.
- 4 KB boundary not checked; submaster guarantees legality.
- W never precedes AW acceptance (legal AXI ordering).

## Timing
- Reset values: state IDLE; awvalid, wvalid, wlast, bready, all xfer_done, sm_wready, resp_err, grant_err = 0; awaddr/awlen latches = 0.
- grant_k at cycle T -> awvalid high at T+1 (registered).
- awvalid&awready at cycle A -> W state from A+1.
- Last W handshake at cycle L -> bready high from L+1.
- bvalid&bready at cycle R -> xfer_done_idx high exactly cycle R+1; IDLE at R+2, new grant accepted from R+2.
- Minimum transfer: 4 cycles from grant to xfer_done with zero-wait slave and len=0.
- Reset asserted mid-burst: all outputs to reset values next edge; no xfer_done issued; beat counter cleared.
- awvalid/wvalid never drop before their ready (except via reset).

## Structure
- Shared package axi_wr_pkg: state enum, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR constants, function for awsize from DATA_W.
- One sub-module natural: axi_wr_beat_ctr (8-bit beat counter with load/clear/inc and last compare); everything else flat.

## Test plan
- Single-beat: grant_1, sm_addr_1=0x1000, len=0, zero-wait slave -> awaddr=0x1000 awlen=0 at T+1, one beat with wlast, xfer_done1 at T+4, only sm_wready_1 ever high.
- 16-beat burst on submaster 2 with wready toggling 1/0 -> exactly 16 handshakes, wlast only on 16th, data order preserved, xfer_done2 once.
- Backpressure: awready held low 5 cycles -> awvalid/awaddr stable 5 cycles, no W activity until AW accepted.
- Error response: bresp=2'b10 on submaster 0 transfer -> xfer_done0 and resp_err_0 pulse together one cycle; next transfer with OKAY leaves resp_err_0 low.
- Protocol abuse: grant_0 mid-burst of submaster 1, and grant_0+grant_2 together in IDLE -> grant_err pulses each time, in-flight burst unaffected, simultaneous case serves submaster 0.
- Reset at beat 3 of an 8-beat burst -> all valids/bready low next cycle, no xfer_done, fresh grant afterwards completes normally.
